phase_scheduler: RTL
====================

# phase_scheduler

Demand-driven phase scheduler for the intersection controller. It decides which of the four signal groups (group1 through, group1 left, group2 through, group2 left) gets right of way, and sequences GREEN → YELLOW → ALL-RED. Arbitration is round-robin over latched vehicle requests, with minimum green, gap extension and maximum green. Its outputs drive the lamp decode, the 7-segment countdown and the 74HC595 LED chain; timing comes from the shared 1 s tick.

## Interface
- CNT_W, 11, width of all second counters and config inputs
- ALLRED_LEN, 1, all-red clearance length in seconds (0 = skip all-red)
- clk  in  1  system clock (12 MHz)
- rst  in  1  synchronous active-high reset
- tick_1s  in  1  one-cycle pulse per second, synchronous to clk
- run  in  1  1 = scheduler advances; 0 = freeze counters and state
- night  in  1  1 = force night (flashing-yellow) mode
- req  in  4  request levels, bit0 group1, bit1 group1L, bit2 group2, bit3 group2L
- green_min  in  CNT_W  minimum green, seconds (0 treated as 1)
- green_max  in  CNT_W  maximum green under extension, seconds
- yellow_len  in  CNT_W  yellow length, seconds (0 treated as 1)
- grant  out  4  one-hot current phase, asserted in GREEN and YELLOW
- yellow  out  1  current phase is in YELLOW
- all_red  out  1  ALL-RED clearance active
- night_mode  out  1  NIGHT state
- cur_phase  out  2  index of current/last served phase
- remaining  out  CNT_W  seconds left in the current interval (display)
- phase_start  out  1  one-cycle pulse on every GREEN entry

## Operation
- States: NIGHT, GREEN, YELLOW, ALLRED. Reset values: state NIGHT, grant 0, yellow 0, all_red 0, night_mode 1, cur_phase 0, remaining 0, phase_start 0, pending 0, next_phase 0.
- Request latching: pending[i] is set when req[i]=1 in any state. It is cleared when phase i enters GREEN. If set and clear happen in the same cycle, clear wins. Pending survives NIGHT and run=0; only rst clears it.
- ext_flag: set when req[cur_phase]=1 during GREEN; cleared on each tick_1s that is processed in GREEN.
- night=1 has priority over everything except rst. The next edge goes to NIGHT: grant 0, remaining 0.
- NIGHT → ALLRED when night=0 and run=1. On this entry remaining=ALLRED_LEN and next_phase=0. If ALLRED_LEN=0, the scheduler goes directly to GREEN phase 0.
- run=0 and night=0: state, remaining and elapsed hold, and ticks are ignored.
- GREEN entry: cur_phase=next_phase, remaining=max(green_min,1), elapsed=0, phase_start=1 for one cycle.
- GREEN, on each tick:
  - elapsed increments, saturating at all-ones.
  - If remaining>1, remaining decrements.
  - Otherwise remaining holds at 1, and the scheduler checks for a change: some other phase has pending set AND (ext_flag=0 OR elapsed+1 ≥ green_max). If true, go to YELLOW and store next_phase.
  - If no other phase is pending, the current phase rests in GREEN indefinitely.
- next_phase selection is round-robin: the first pending index among cur+1, cur+2, cur+3 (mod 4).
- YELLOW: remaining=max(yellow_len,1) on entry. Each tick decrements it; on the tick with remaining=1, go to ALLRED (remaining=ALLRED_LEN), or straight to GREEN if ALLRED_LEN=0.
- ALLRED: each tick decrements remaining; on the tick with remaining=1, go to GREEN of next_phase.
- Config inputs are sampled only at interval entry. Changes mid-interval take effect at the next entry.

## Timing
- All outputs are registered.
- A tick in cycle t takes effect at the edge ending t, visible in cycle t+1. An interval of N seconds therefore spans exactly N processed ticks.
- Arbitration uses only the pending register. A req that is first high in the same cycle as the deciding tick is not considered until the next tick.
- night asserted in cycle t: night_mode=1 in t+1, regardless of tick or run.
- rst in cycle t: all outputs hold their reset values in t+1. This applies mid-interval too.
- phase_start is high exactly one cycle, coincident with the first cycle of grant for the new phase.

## Test plan
Common settings: green_min=3, green_max=6, yellow_len=2, ALLRED_LEN=1.
- Startup: rst then night=0, run=1 → ALLRED (remaining 1). After 1 tick: GREEN phase 0, grant=0001, remaining=3, phase_start pulse. With no requests, grant stays 0001 and remaining holds 1 for 10 ticks.
- Single request: 1-cycle req[2] pulse after green entry → YELLOW on 3rd tick (grant 0001, yellow=1, remaining=2) → ALLRED after 2 ticks → GREEN grant=0100 after 1 tick. pending[2]=0 from that point.
- Extension: req[0] held high, pending[1]=1 → YELLOW on 6th tick (max-out). The same test with req[0] low after tick 2 → YELLOW on 3rd tick (gap-out).
- Round-robin: phase 2 green, pending={0,1,3} → served order 3, 0, 1, with grant 1000, 0001, 0010.
- Night mid-YELLOW: night=1 → next cycle night_mode=1, grant=0, remaining=0, pending retained. Release night → ALLRED → GREEN phase 0.
- Freeze and reset: run=0 for 5 ticks mid-GREEN → remaining unchanged. rst pulsed mid-ALLRED → next cycle NIGHT with all reset values.

Source files
------------

// File: rtl/phase_scheduler.sv
// Demand-driven round-robin phase scheduler: GREEN -> YELLOW -> ALL-RED over four
// signal groups, with minimum green, gap extension, maximum green and night flash.
module phase_scheduler #(
    parameter int CNT_W      = 11,
    parameter int ALLRED_LEN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_1s,
    input  logic             run,
    input  logic             night,
    input  logic [3:0]       req,
    input  logic [CNT_W-1:0] green_min,
    input  logic [CNT_W-1:0] green_max,
    input  logic [CNT_W-1:0] yellow_len,
    output logic [3:0]       grant,
    output logic             yellow,
    output logic             all_red,
    output logic             night_mode,
    output logic [1:0]       cur_phase,
    output logic [CNT_W-1:0] remaining,
    output logic             phase_start
);

    localparam logic [1:0] S_NIGHT  = 2'd0;
    localparam logic [1:0] S_GREEN  = 2'd1;
    localparam logic [1:0] S_YELLOW = 2'd2;
    localparam logic [1:0] S_ALLRED = 2'd3;

    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
    localparam logic [CNT_W-1:0] ALL_ONES   = '1;
    localparam logic [CNT_W-1:0] ALLRED_CNT = CNT_W'(ALLRED_LEN);

    logic [1:0]       state_reg, state_next;
    logic [3:0]       grant_reg, grant_next;
    logic             yellow_reg, yellow_next;
    logic             all_red_reg, all_red_next;
    logic             night_mode_reg, night_mode_next;
    logic [1:0]       cur_phase_reg, cur_phase_next;
    logic [CNT_W-1:0] remaining_reg, remaining_next;
    logic             phase_start_reg, phase_start_next;
    logic [3:0]       pending_reg, pending_next;
    logic [1:0]       next_phase_reg, next_phase_next;
    logic [CNT_W-1:0] elapsed_reg, elapsed_next;
    logic [CNT_W-1:0] gmax_reg, gmax_next;
    logic             ext_flag_reg, ext_flag_next;

    logic [3:0]       cur_onehot;
    logic [2:0]       rot_pending;
    logic [1:0]       rr_phase;
    logic             other_pending;
    logic [CNT_W-1:0] green_len;
    logic [CNT_W-1:0] yellow_cnt;
    logic [CNT_W-1:0] elapsed_inc;
    logic [CNT_W:0]   elapsed_plus;
    logic             max_reached;
    logic             enter_green;
    logic [1:0]       green_phase;
    logic [3:0]       green_mask;

    // rot_pending[k] looks at phase cur+k+1, so the first set bit is the round-robin winner.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_cur
            assign cur_onehot[gi] = (cur_phase_reg == 2'(gi));
        end
        for (gi = 0; gi < 3; gi++) begin : g_rot
            assign rot_pending[gi] = pending_reg[cur_phase_reg + 2'(gi + 1)];
        end
    endgenerate

    always_comb begin
        rr_phase = cur_phase_reg + 2'd3;
        if (rot_pending[0]) begin
            rr_phase = cur_phase_reg + 2'd1;
        end else if (rot_pending[1]) begin
            rr_phase = cur_phase_reg + 2'd2;
        end
    end

    assign other_pending = |(pending_reg & ~cur_onehot);
    assign green_len     = (green_min == '0) ? ONE : green_min;
    assign yellow_cnt    = (yellow_len == '0) ? ONE : yellow_len;
    assign elapsed_inc   = (elapsed_reg == ALL_ONES) ? elapsed_reg : elapsed_reg + ONE;
    assign elapsed_plus  = {1'b0, elapsed_reg} + (CNT_W + 1)'(1);
    assign max_reached   = (elapsed_plus >= {1'b0, gmax_reg});

    always_comb begin
        state_next       = state_reg;
        grant_next       = grant_reg;
        yellow_next      = yellow_reg;
        all_red_next     = all_red_reg;
        night_mode_next  = night_mode_reg;
        cur_phase_next   = cur_phase_reg;
        remaining_next   = remaining_reg;
        phase_start_next = 1'b0;
        next_phase_next  = next_phase_reg;
        elapsed_next     = elapsed_reg;
        gmax_next        = gmax_reg;
        ext_flag_next    = ext_flag_reg;
        enter_green      = 1'b0;
        green_phase      = next_phase_reg;

        if (night) begin
            state_next      = S_NIGHT;
            grant_next      = 4'b0000;
            yellow_next     = 1'b0;
            all_red_next    = 1'b0;
            night_mode_next = 1'b1;
            remaining_next  = '0;
            ext_flag_next   = 1'b0;
        end else if (run) begin
            case (state_reg)
                S_NIGHT: begin
                    next_phase_next = 2'd0;
                    if (ALLRED_LEN == 0) begin
                        enter_green = 1'b1;
                        green_phase = 2'd0;
                    end else begin
                        state_next      = S_ALLRED;
                        all_red_next    = 1'b1;
                        night_mode_next = 1'b0;
                        remaining_next  = ALLRED_CNT;
                    end
                end
                S_GREEN: begin
                    // A tick always clears the gap flag; a request on the same cycle is lost.
                    if (tick_1s) begin
                        ext_flag_next = 1'b0;
                        elapsed_next  = elapsed_inc;
                        if (remaining_reg > ONE) begin
                            remaining_next = remaining_reg - ONE;
                        end else if (other_pending && (!ext_flag_reg || max_reached)) begin
                            state_next      = S_YELLOW;
                            yellow_next     = 1'b1;
                            next_phase_next = rr_phase;
                            remaining_next  = yellow_cnt;
                        end
                    end else if (req[cur_phase_reg]) begin
                        ext_flag_next = 1'b1;
                    end
                end
                S_YELLOW: begin
                    if (tick_1s) begin
                        if (remaining_reg > ONE) begin
                            remaining_next = remaining_reg - ONE;
                        end else if (ALLRED_LEN == 0) begin
                            enter_green = 1'b1;
                        end else begin
                            state_next     = S_ALLRED;
                            grant_next     = 4'b0000;
                            yellow_next    = 1'b0;
                            all_red_next   = 1'b1;
                            remaining_next = ALLRED_CNT;
                        end
                    end
                end
                default: begin
                    if (tick_1s) begin
                        if (remaining_reg > ONE) begin
                            remaining_next = remaining_reg - ONE;
                        end else begin
                            enter_green = 1'b1;
                        end
                    end
                end
            endcase
        end

        if (enter_green) begin
            state_next       = S_GREEN;
            cur_phase_next   = green_phase;
            grant_next       = 4'b0001 << green_phase;
            yellow_next      = 1'b0;
            all_red_next     = 1'b0;
            night_mode_next  = 1'b0;
            remaining_next   = green_len;
            elapsed_next     = '0;
            gmax_next        = green_max;
            ext_flag_next    = 1'b0;
            phase_start_next = 1'b1;
        end
    end

    // Clearing on GREEN entry overrides a request arriving in the same cycle.
    assign green_mask   = enter_green ? (4'b0001 << green_phase) : 4'b0000;
    assign pending_next = (pending_reg | req) & ~green_mask;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= S_NIGHT;
            grant_reg       <= 4'b0000;
            yellow_reg      <= 1'b0;
            all_red_reg     <= 1'b0;
            night_mode_reg  <= 1'b1;
            cur_phase_reg   <= 2'd0;
            remaining_reg   <= '0;
            phase_start_reg <= 1'b0;
            pending_reg     <= 4'b0000;
            next_phase_reg  <= 2'd0;
            elapsed_reg     <= '0;
            gmax_reg        <= '0;
            ext_flag_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            grant_reg       <= grant_next;
            yellow_reg      <= yellow_next;
            all_red_reg     <= all_red_next;
            night_mode_reg  <= night_mode_next;
            cur_phase_reg   <= cur_phase_next;
            remaining_reg   <= remaining_next;
            phase_start_reg <= phase_start_next;
            pending_reg     <= pending_next;
            next_phase_reg  <= next_phase_next;
            elapsed_reg     <= elapsed_next;
            gmax_reg        <= gmax_next;
            ext_flag_reg    <= ext_flag_next;
        end
    end

    assign grant       = grant_reg;
    assign yellow      = yellow_reg;
    assign all_red     = all_red_reg;
    assign night_mode  = night_mode_reg;
    assign cur_phase   = cur_phase_reg;
    assign remaining   = remaining_reg;
    assign phase_start = phase_start_reg;

endmodule
